// File: rtl/decode_stage_if.sv
// Handshake bundle between an instruction source, the decode stage and its consumer.
// master drives instructions/flush/out_ready; slave is the decode stage itself.
interface decode_stage_if #(
  parameter int ALU_W = 6,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [ALU_W-1:0] alu_control;
  logic [5:0]       branch;
  logic             lw;
  logic             lwi;
  logic             sw;
  logic             jmp;
  logic             illegal;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output flush, in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_control, branch, lw, lwi, sw, jmp, illegal,
    input  retired_cnt, illegal_cnt
  );

  modport slave (
    input  flush, in_valid, instr, out_ready,
    output in_ready, out_valid, alu_control, branch, lw, lwi, sw, jmp, illegal,
    output retired_cnt, illegal_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: one output register plus a skid register, 1-cycle latency.
// Backpressure: in_ready is simply !skid_valid, so it never depends on out_ready combinationally.
module decode_stage #(
  parameter int         ALU_W = 6,
  parameter int         CNT_W = 16,
  parameter logic [6:0] OP_R  = 7'b0110011,
  parameter logic [6:0] OP_I  = 7'b1001100,
  parameter logic [6:0] OP_CT = 7'b1010101
) (
  input logic           clk,
  input logic           reset,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic       illegal;
    logic [5:0] alu;
    logic [5:0] branch;
    logic       lw;
    logic       lwi;
    logic       sw;
    logic       jmp;
  } ctrl_t;

  ctrl_t            dec;
  ctrl_t            out_dat;
  ctrl_t            skid_dat;
  logic             out_vld;
  logic             skid_vld;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] illegal_q;
  logic             take;
  logic             accept;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             unused_instr_bits;

  assign opcode            = bus.instr[6:0];
  assign funct3            = bus.instr[14:12];
  assign funct7            = bus.instr[31:25];
  assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};

  // Illegal paths only ever set the illegal bit, so the other controls stay zero.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000)
          dec.alu = {3'b000, funct3};
        else if (funct7 == 7'b0100000 && funct3 == 3'b010)
          dec.alu = 6'd8;
        else if (funct7 == 7'b0100000 && funct3 == 3'b011)
          dec.alu = 6'd9;
        else
          dec.illegal = 1'b1;
      end
      OP_I: dec.alu = 6'd63 - {3'b000, funct3};
      OP_CT: begin
        case (funct3)
          3'b000: dec.jmp = 1'b1;
          3'b111: begin
            case (funct7)
              7'b1111111: dec.lwi = 1'b1;
              7'b0001000: dec.sw  = 1'b1;
              7'b0000000: dec.lw  = 1'b1;
              default:    dec.illegal = 1'b1;
            endcase
          end
          default: dec.branch = 6'b000001 << (funct3 - 3'd1);
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign take   = out_vld & bus.out_ready;
  assign accept = bus.in_valid & ~skid_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld   <= 1'b0;
      skid_vld  <= 1'b0;
      out_dat   <= '0;
      skid_dat  <= '0;
      retired_q <= '0;
      illegal_q <= '0;
    end else begin
      // A handshake coinciding with flush still retires.
      if (take && retired_q != '1)
        retired_q <= retired_q + CNT_W'(1);
      if (bus.flush) begin
        out_vld  <= 1'b0;
        skid_vld <= 1'b0;
      end else begin
        if (accept && dec.illegal && illegal_q != '1)
          illegal_q <= illegal_q + CNT_W'(1);
        if (take) begin
          if (skid_vld) begin
            out_dat  <= skid_dat;
            skid_vld <= 1'b0;
          end else begin
            out_vld <= 1'b0;
          end
        end
        // accept implies the skid register is empty, so this never races the skid move above.
        if (accept) begin
          if (!out_vld || take) begin
            out_dat <= dec;
            out_vld <= 1'b1;
          end else begin
            skid_dat <= dec;
            skid_vld <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.in_ready    = ~skid_vld;
  assign bus.out_valid   = out_vld;
  assign bus.alu_control = ALU_W'(out_dat.alu);
  assign bus.branch      = out_dat.branch;
  assign bus.lw          = out_dat.lw;
  assign bus.lwi         = out_dat.lwi;
  assign bus.sw          = out_dat.sw;
  assign bus.jmp         = out_dat.jmp;
  assign bus.illegal     = out_dat.illegal;
  assign bus.retired_cnt = retired_q;
  assign bus.illegal_cnt = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: queue-based reference model checked every cycle, plus directed literal checks.
// Two instances share stimulus: default widths, and ALU_W=8/CNT_W=2 for zero-extension and saturation.
module tb_decode_stage;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b1001100;
  localparam logic [6:0] OP_CT = 7'b1010101;

  typedef struct packed {
    logic       ill;
    logic [5:0] alu;
    logic [5:0] br;
    logic       lw;
    logic       lwi;
    logic       sw;
    logic       jmp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.ALU_W(6), .CNT_W(16)) b0 ();
  decode_stage_if #(.ALU_W(8), .CNT_W(2))  b1 ();

  assign b0.flush = flush;  assign b0.in_valid = in_valid;
  assign b0.instr = instr;  assign b0.out_ready = out_ready;
  assign b1.flush = flush;  assign b1.in_valid = in_valid;
  assign b1.instr = instr;  assign b1.out_ready = out_ready;

  decode_stage #(.ALU_W(6), .CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(b0.slave));
  decode_stage #(.ALU_W(8), .CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(b1.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode table written straight from the opcode/funct rules.
  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    e  = '0;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == OP_R && f7 == 7'h00)                     e.alu = {3'b000, f3};
    else if (op == OP_R && f7 == 7'h20 && f3 == 3'd2)  e.alu = 6'd8;
    else if (op == OP_R && f7 == 7'h20 && f3 == 3'd3)  e.alu = 6'd9;
    else if (op == OP_I)                               e.alu = 6'(63 - int'(f3));
    else if (op == OP_CT && f3 == 3'd0)                e.jmp = 1'b1;
    else if (op == OP_CT && f3 != 3'd7)                e.br  = 6'(1 << (int'(f3) - 1));
    else if (op == OP_CT && f7 == 7'h7F)               e.lwi = 1'b1;
    else if (op == OP_CT && f7 == 7'h08)               e.sw  = 1'b1;
    else if (op == OP_CT && f7 == 7'h00)               e.lw  = 1'b1;
    else                                               e.ill = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 3))
      0: w[6:0] = OP_R;
      1: w[6:0] = OP_I;
      2: w[6:0] = OP_CT;
      default: ;
    endcase
    case ($urandom_range(0, 4))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h7F;
      3: w[31:25] = 7'h08;
      default: ;
    endcase
    return w;
  endfunction

  // Reference model: words held in the stage form a queue of depth at most two.
  exp_t        q[$];
  int unsigned m_ret = 0;
  int unsigned m_ill = 0;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin : model_upd
    bit   tk;
    bit   ac;
    exp_t d;
    if (reset) begin
      q.delete();
      m_ret = 0;
      m_ill = 0;
    end else begin
      tk = (q.size() > 0) && out_ready;
      ac = in_valid && (q.size() < 2);
      if (tk) m_ret++;
      if (flush) begin
        q.delete();
      end else begin
        if (tk) void'(q.pop_front());
        if (ac) begin
          d = ref_dec(instr);
          q.push_back(d);
          if (d.ill) m_ill++;
        end
      end
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin : compare
    exp_t e;
    if (model_ok) begin
      chk("in_ready",    32'(b0.in_ready),  32'(q.size() < 2));
      chk("out_valid",   32'(b0.out_valid), 32'(q.size() > 0));
      chk("s_out_valid", 32'(b1.out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        e = q[0];
        chk("alu",     32'(b0.alu_control), 32'(e.alu));
        chk("s_alu",   32'(b1.alu_control), 32'(e.alu));
        chk("branch",  32'(b0.branch),      32'(e.br));
        chk("flags",   32'({b0.illegal, b0.lw, b0.lwi, b0.sw, b0.jmp}),
                       32'({e.ill, e.lw, e.lwi, e.sw, e.jmp}));
      end
      chk("retired",   32'(b0.retired_cnt), (m_ret > 65535) ? 32'd65535 : m_ret);
      chk("illcnt",    32'(b0.illegal_cnt), (m_ill > 65535) ? 32'd65535 : m_ill);
      chk("s_retired", 32'(b1.retired_cnt), (m_ret > 3) ? 32'd3 : m_ret);
      chk("s_illcnt",  32'(b1.illegal_cnt), (m_ill > 3) ? 32'd3 : m_ill);
    end
  end

  task automatic cyc(input bit v, input logic [31:0] w);
    in_valid = v;
    instr    = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ov"},  32'(b0.out_valid), 32'd0);
    chk({name, "_ir"},  32'(b0.in_ready),  32'd1);
    chk({name, "_ctl"}, 32'({b0.alu_control, b0.branch, b0.lw, b0.lwi, b0.sw, b0.jmp, b0.illegal}), 32'd0);
    chk({name, "_cnt"}, {b0.retired_cnt, b0.illegal_cnt}, 32'd0);
    chk({name, "_scnt"}, 32'({b1.retired_cnt, b1.illegal_cnt}), 32'd0);
  endtask

  initial begin
    bit got;
    bit rdy;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all_zero("reset");

    // Pin the reference decoder against hand-decoded words.
    chk("ref_add",  32'(ref_dec(32'h00000033).alu), 32'd0);
    chk("ref_sub",  32'(ref_dec(32'h40002033).alu), 32'd8);
    chk("ref_sra",  32'(ref_dec(32'h40003033).alu), 32'd9);
    chk("ref_addi", 32'(ref_dec(32'h0000004C).alu), 32'd63);
    chk("ref_beq",  32'(ref_dec(32'h00001055).br),  32'h01);
    chk("ref_bgeu", 32'(ref_dec(32'h00006055).br),  32'h20);
    chk("ref_ill",  32'(ref_dec(32'h00000013)),     32'h10000);

    // ADD then SUB back to back.
    out_ready = 1'b1;
    cyc(1'b1, 32'h00000033);
    chk("add_lat", 32'({b0.out_valid, b0.alu_control}), 32'({1'b1, 6'd0}));
    cyc(1'b1, 32'h40002033);
    chk("sub_lat", 32'({b0.out_valid, b0.alu_control}), 32'({1'b1, 6'd8}));
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    chk("ret2", 32'(b0.retired_cnt), 32'd2);

    // Spot decodes with literal expectations.
    cyc(1'b1, 32'h0000004C);  chk("addi",  32'(b0.alu_control), 32'd63);
    cyc(1'b1, 32'h00001055);  chk("beq",   32'({b0.branch, b0.alu_control}), 32'({6'b000001, 6'd0}));
    cyc(1'b1, 32'h00007055);  chk("lw",    32'({b0.lw, b0.sw, b0.lwi}), 32'b100);
    cyc(1'b1, 32'h10007055);  chk("sw",    32'({b0.lw, b0.sw, b0.lwi}), 32'b010);
    cyc(1'b1, 32'hFE007055);  chk("lwi",   32'({b0.lw, b0.sw, b0.lwi}), 32'b001);
    cyc(1'b1, 32'h00000013);
    chk("ill", 32'({b0.illegal, b0.alu_control, b0.branch, b0.lw, b0.lwi, b0.sw, b0.jmp}), 32'h10000);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    chk("illcnt1", 32'(b0.illegal_cnt), 32'd1);

    // Backpressure: two held, third waits, drain in order.
    out_ready = 1'b0;
    cyc(1'b1, 32'h00000033);
    cyc(1'b1, 32'h00001033);
    chk("full_ir", 32'(b0.in_ready), 32'd0);
    cyc(1'b1, 32'h00002033);
    chk("hold_alu", 32'({b0.out_valid, b0.alu_control}), 32'({1'b1, 6'd0}));
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      rdy = b0.in_ready;
      in_valid = 1'b1;
      instr = 32'h00002033;
      @(posedge clk);
      #1;
      if (i == 0) chk("skid_move", 32'(b0.alu_control), 32'd1);
      got = rdy;
    end
    in_valid = 1'b0;
    if (!got) begin
      errors++;
      $display("FAIL third_accept: got no acceptance expected acceptance within 10 cycles");
    end
    repeat (3) cyc(1'b0, '0);

    // Flush with both registers full; the presented illegal word is discarded.
    out_ready = 1'b0;
    cyc(1'b1, 32'h00000033);
    cyc(1'b1, 32'h00001033);
    flush = 1'b1;
    cyc(1'b1, 32'h00000013);
    flush = 1'b0;
    chk("flush_ov",  32'(b0.out_valid), 32'd0);
    chk("flush_ir",  32'(b0.in_ready),  32'd1);
    chk("flush_ret", 32'(b0.retired_cnt), 32'd11);
    chk("flush_ill", 32'(b0.illegal_cnt), 32'd1);
    chk("sat_ret",   32'(b1.retired_cnt), 32'd3);

    // Reset mid-stream overrides flush and handshakes.
    cyc(1'b1, 32'h0000004C);
    cyc(1'b1, 32'h00000013);
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
    cyc(1'b1, 32'h00000013);
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    chk_all_zero("midreset");

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 3);
      reset     = ($urandom_range(0, 399) == 0);
      instr     = rnd_instr();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
